// File: rtl/sum_accum_ctrl_pkg.sv
// Shared types and sizing helpers for the byte-serial accumulation controller.
package sum_accum_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int ACC_BYTES_DFLT = 3;
    localparam int ACC_W_DFLT     = 8 * ACC_BYTES_DFLT;

    function automatic int acc_width(input int nbytes);
        return 8 * nbytes;
    endfunction

    // Byte index needs at least one bit even for a single-byte accumulator.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

// File: rtl/adder_ckt_8_bit.sv
// 8-bit ripple-carry adder shared by the accumulator datapath.
// Purely combinational; no latency, no backpressure.
module adder_ckt_8_bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    always_comb begin
        logic carry;
        sum_o = '0;
        carry = cin_i;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry;
    end

endmodule

// File: rtl/sum_accum_ctrl.sv
// Byte-serial sample accumulator: one shared 8-bit adder walks the accumulator a byte per cycle.
// Latency ACC_BYTES cycles per sample; in_ready drops while a sample is being added.
module sum_accum_ctrl
    import sum_accum_ctrl_pkg::*;
#(
    parameter int ACC_BYTES = 3,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_samples,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   done,
    output logic [8*ACC_BYTES-1:0] acc_sum,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic                   overflow
);

    localparam int ACC_W = acc_width(ACC_BYTES);
    localparam int IDX_W = idx_width(ACC_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_BYTES - 1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_q, ovf_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         sample_q, sample_d;

    logic [7:0]         add_a, add_b, add_sum;
    logic               add_cin, add_cout;

    always_comb begin
        add_a = '0;
        for (int b = 0; b < ACC_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) add_a = acc_q[b*8 +: 8];
        end
    end

    // The sample only enters at byte 0; upper bytes just absorb the carry.
    assign add_b   = (idx_q == '0) ? sample_q : 8'h00;
    assign add_cin = (idx_q == '0) ? 1'b0 : carry_q;
    assign cnt_inc = cnt_q + 1'b1;

    adder_ckt_8_bit u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        ovf_d    = ovf_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    ovf_d    = 1'b0;
                    target_d = num_samples;
                    state_d  = (num_samples == '0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (in_valid) begin
                    sample_d = in_data;
                    idx_d    = '0;
                    state_d  = ST_ADD;
                end
            end
            ST_ADD: begin
                for (int b = 0; b < ACC_BYTES; b++) begin
                    if (idx_q == IDX_W'(b)) acc_d[b*8 +: 8] = add_sum;
                end
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    cnt_d = cnt_inc;
                    if (add_cout) ovf_d = 1'b1;
                    state_d = (cnt_inc == target_q) ? ST_DONE : ST_WAIT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            ovf_q    <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            ovf_q    <= ovf_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
        end
    end

    assign in_ready   = (state_q == ST_WAIT);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign acc_sum    = acc_q;
    assign sample_cnt = cnt_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_sum_accum_ctrl.sv
// Bench for sum_accum_ctrl: a 1-byte and a 3-byte instance checked against a sum-of-samples model.
module tb_sum_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [2];
    logic [9:0]  num [2];
    logic        in_valid [2];
    logic [7:0]  in_data [2];
    logic        in_ready [2];
    logic        busy [2];
    logic        done [2];
    logic        overflow [2];
    logic [7:0]  acc0;
    logic [23:0] acc1;
    logic [9:0]  cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    sum_accum_ctrl #(.ACC_BYTES(1), .CNT_W(10)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .num_samples(num[0]),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .busy(busy[0]), .done(done[0]), .acc_sum(acc0), .sample_cnt(cnt0),
        .overflow(overflow[0])
    );

    sum_accum_ctrl #(.ACC_BYTES(3), .CNT_W(10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .num_samples(num[1]),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .busy(busy[1]), .done(done[1]), .acc_sum(acc1), .sample_cnt(cnt1),
        .overflow(overflow[1])
    );

    function automatic logic [31:0] acc_of(input int s);
        return (s != 0) ? {8'h0, acc1} : {24'h0, acc0};
    endfunction

    function automatic logic [31:0] cnt_of(input int s);
        return (s != 0) ? {22'h0, cnt1} : {22'h0, cnt0};
    endfunction

    function automatic int bytes_of(input int s);
        return (s != 0) ? 3 : 1;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One accumulation run; the model is just the running sum of the presented samples.
    task automatic run_txn(input int s, input int n, input logic [7:0] smp[$],
                           input int stall, input bit noisy);
        longint total = 0;
        longint m = longint'(1) << (8 * bytes_of(s));
        int c;
        int st;
        c = 0;
        while (busy[s] && c < 50) begin
            @(negedge clk);
            c++;
        end
        start[s] = 1'b1;
        num[s]   = 10'(n);
        @(negedge clk);
        start[s] = 1'b0;
        num[s]   = 10'($urandom);
        check_val("busy_after_start", 32'(busy[s]), 32'd1);
        if (n == 0) begin
            check_val("zero_done", 32'(done[s]), 32'd1);
            check_val("zero_rdy", 32'(in_ready[s]), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            st = (stall < 0) ? $urandom_range(3, 0) : stall;
            for (int k = 0; k < st; k++) begin
                in_valid[s] = 1'b0;
                in_data[s]  = 8'($urandom);
                if (noisy) begin
                    start[s] = 1'b1;
                    num[s]   = 10'($urandom);
                end
                @(negedge clk);
            end
            check_val("wait_rdy", 32'(in_ready[s]), 32'd1);
            check_val("wait_acc", acc_of(s), 32'(total % m));
            check_val("wait_cnt", cnt_of(s), 32'(i));
            in_valid[s] = 1'b1;
            in_data[s]  = smp[i];
            @(negedge clk);
            in_valid[s] = 1'b0;
            in_data[s]  = 8'($urandom);
            start[s]    = noisy && (i < n - 1);
            num[s]      = 10'($urandom);
            total += smp[i];
            c = 0;
            while (!in_ready[s] && !done[s] && c < 20) begin
                c++;
                @(negedge clk);
            end
            check_val("add_cycles", 32'(c), 32'(bytes_of(s)));
            if (i == n - 1) check_val("done_after_last", 32'(done[s]), 32'd1);
            else            check_val("rdy_after_add", 32'(in_ready[s]), 32'd1);
        end
        start[s] = 1'b0;
        check_val("done_acc", acc_of(s), 32'(total % m));
        check_val("done_cnt", cnt_of(s), 32'(n));
        check_val("done_ovf", 32'(overflow[s]), 32'(total >= m));
        check_val("done_rdy", 32'(in_ready[s]), 32'd0);
        // A start raised while done is high must not launch a new run.
        start[s] = 1'b1;
        num[s]   = 10'd5;
        @(negedge clk);
        start[s] = 1'b0;
        check_val("idle_busy", 32'(busy[s]), 32'd0);
        check_val("done_pulse", 32'(done[s]), 32'd0);
        check_val("hold_acc", acc_of(s), 32'(total % m));
        check_val("hold_ovf", 32'(overflow[s]), 32'(total >= m));
    endtask

    initial begin
        int s, n;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            num[i] = '0;
            in_valid[i] = 1'b0;
            in_data[i] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_val("rst_acc", acc_of(i), 32'd0);
            check_val("rst_cnt", cnt_of(i), 32'd0);
            check_val("rst_flags", {28'd0, busy[i], done[i], in_ready[i], overflow[i]}, 32'd0);
        end

        q.delete(); q.push_back(8'd10); q.push_back(8'd20); q.push_back(8'd30);
        run_txn(1, 3, q, 0, 1'b0);
        check_val("basic_sum", acc_of(1), 32'h3C);

        q.delete(); q.push_back(8'hFF); q.push_back(8'hFF);
        run_txn(1, 2, q, 0, 1'b0);
        check_val("ripple_sum", acc_of(1), 32'h1FE);
        q.delete();
        for (int i = 0; i < 257; i++) q.push_back(8'hFF);
        run_txn(1, 257, q, 0, 1'b0);

        q.delete(); q.push_back(8'd200); q.push_back(8'd100);
        run_txn(0, 2, q, 0, 1'b0);
        check_val("wrap_sum", acc_of(0), 32'h2C);
        check_val("wrap_ovf", 32'(overflow[0]), 32'd1);
        q.delete(); q.push_back(8'd5);
        run_txn(0, 1, q, 0, 1'b0);
        check_val("ovf_cleared", 32'(overflow[0]), 32'd0);

        q.delete();
        run_txn(1, 0, q, 0, 1'b0);
        run_txn(0, 0, q, 0, 1'b0);

        q.delete(); q.push_back(8'd33); q.push_back(8'd44);
        run_txn(1, 2, q, 2, 1'b1);
        check_val("noisy_start_sum", acc_of(1), 32'd77);

        q.delete(); q.push_back(8'd9); q.push_back(8'd7);
        run_txn(1, 2, q, 20, 1'b0);

        // Reset landing in the second ADD cycle of a 3-byte run.
        @(negedge clk);
        start[1] = 1'b1;
        num[1]   = 10'd2;
        @(negedge clk);
        start[1]    = 1'b0;
        in_valid[1] = 1'b1;
        in_data[1]  = 8'd9;
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_val("midrst_acc", acc_of(1), 32'd0);
        check_val("midrst_cnt", cnt_of(1), 32'd0);
        check_val("midrst_flags", {28'd0, busy[1], done[1], in_ready[1], overflow[1]}, 32'd0);
        q.delete(); q.push_back(8'd1); q.push_back(8'd2);
        run_txn(1, 2, q, 0, 1'b0);
        check_val("post_rst_sum", acc_of(1), 32'd3);

        for (int t = 0; t < 24; t++) begin
            s = $urandom_range(1, 0);
            n = $urandom_range(12, 0);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            run_txn(s, n, q, -1, bit'($urandom_range(1, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
